// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the asynchronous 7-bit address / 8-bit data memory bus.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_valid/req_ready        request handshake; req_write/req_addr/req_wdata latched on acceptance
//   rsp_valid/rsp_rdata        one-cycle read-complete pulse and captured read data
//   busy                       transaction in progress (inverse of req_ready)
//   ce_n/read_n/write_n        active-low bus strobes
//   address_bus/data_bus       bus address and bidirectional data (driven only for writes)
module mem_bus_master #(
    parameter int unsigned SETUP_CYCLES     = 1,
    parameter int unsigned WR_STROBE_CYCLES = 5,
    parameter int unsigned RD_STROBE_CYCLES = 3,
    parameter int unsigned HOLD_CYCLES      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       ce_n,
    output logic       read_n,
    output logic       write_n,
    output logic [6:0] address_bus,
    inout  wire  [7:0] data_bus
);
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || WR_STROBE_CYCLES < 1 || WR_STROBE_CYCLES > 15 ||
        RD_STROBE_CYCLES < 1 || RD_STROBE_CYCLES > 15 || HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_param
        $error("mem_bus_master: phase lengths must be within 1..15");
    end

    // The phase counter runs down to zero, so each phase loads its length minus one.
    localparam logic [3:0] SETUP_LEN = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] WR_LEN    = 4'(WR_STROBE_CYCLES - 1);
    localparam logic [3:0] RD_LEN    = 4'(RD_STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LEN  = 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       rsp_valid_q;
    logic       drive;

    wire accept  = req_valid && state_q == IDLE;
    wire done    = cnt_q == 4'd0;
    // Final read strobe cycle: the edge ending it samples the bus.
    wire last_rd = state_q == STROBE && done && !write_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= last_rd;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (last_rd) rdata_q <= data_bus;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 4'd1;
        case (state_q)
            IDLE: begin
                cnt_d = SETUP_LEN;
                if (accept) state_d = SETUP;
            end
            SETUP: if (done) begin
                state_d = STROBE;
                cnt_d   = write_q ? WR_LEN : RD_LEN;
            end
            STROBE: if (done) begin
                state_d = HOLD;
                cnt_d   = HOLD_LEN;
            end
            HOLD: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ce_n    = !(state_q == SETUP || state_q == STROBE);
        write_n = !(state_q == STROBE && write_q);
        read_n  = !(state_q == STROBE && !write_q);
        drive   = write_q && state_q != IDLE;
    end

    assign req_ready   = state_q == IDLE && !reset;
    assign busy        = !req_ready;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign address_bus = addr_q;
    assign data_bus    = drive ? wdata_q : 8'hzz;
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: directed self-checking bench for mem_bus_master (default and swept parameters).
module tb_mem_bus_master;
    // The bus is pulled up, so an undriven data_bus reads as this value.
    localparam logic [7:0] ZB = 8'hFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mon_en = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         gap = 0;
    int         last_gap = 0;

    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, busy, ce_n, read_n, write_n;
    logic [7:0] rsp_rdata;
    logic [6:0] address_bus;
    wire  [7:0] data_bus;
    logic [7:0] mem [128];

    logic       valid2 = 1'b0, write2 = 1'b0;
    logic [6:0] addr2 = '0;
    logic [7:0] wdata2 = '0;
    logic       ready2, rsp_valid2, busy2, ce_n2, read_n2, write_n2;
    logic [7:0] rdata2;
    logic [6:0] address_bus2;
    wire  [7:0] data_bus2;

    always #5 clk = ~clk;

    mem_bus_master dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ce_n(ce_n), .read_n(read_n), .write_n(write_n),
        .address_bus(address_bus), .data_bus(data_bus)
    );

    mem_bus_master #(.SETUP_CYCLES(2), .WR_STROBE_CYCLES(1), .RD_STROBE_CYCLES(1), .HOLD_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset), .req_valid(valid2), .req_ready(ready2),
        .req_write(write2), .req_addr(addr2), .req_wdata(wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rdata2), .busy(busy2),
        .ce_n(ce_n2), .read_n(read_n2), .write_n(write_n2),
        .address_bus(address_bus2), .data_bus(data_bus2)
    );

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (data_bus[i]);
        pullup (data_bus2[i]);
    end

    // Memory on the far side: responds to read strobes, captures on write strobes.
    assign data_bus  = (!ce_n && !read_n) ? mem[address_bus] : 8'hzz;
    assign data_bus2 = (!ce_n2 && !read_n2) ? 8'hC3 : 8'hzz;
    always @(posedge clk) if (!ce_n && !write_n) mem[address_bus] <= data_bus;

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            assert ((read_n | write_n) && (!ce_n || (read_n & write_n)) &&
                    (read_n2 | write_n2) && (!ce_n2 || (read_n2 & write_n2)))
            else begin
                n_fail++;
                $display("FAIL strobe_invariant ce/rd/wr=%b%b%b dut2=%b%b%b required no overlap and no strobe with ce_n high",
                         ce_n, read_n, write_n, ce_n2, read_n2, write_n2);
            end
            if (ce_n) gap++;
            else begin
                if (gap != 0) last_gap = gap;
                gap = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Starts at a negedge in IDLE; checks every cycle against the default-parameter timing.
    // For reads, d is the data the memory model is expected to return.
    task automatic run_txn(input logic wr, input logic [6:0] a, input logic [7:0] d);
        int n = wr ? 8 : 6;
        logic [19:0] act, exp;
        logic e_ce, e_wr, e_rd, e_rsp;
        logic [7:0] e_dat;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL txn_start_ready got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wr ? d : ~d;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            req_valid = 1'b0; req_addr = ~a; req_wdata = 8'h00;
            if (wr) begin
                e_ce = k > 6; e_wr = !(k >= 2 && k <= 6); e_rd = 1'b1; e_rsp = 1'b0;
                e_dat = k <= 7 ? d : ZB;
            end else begin
                e_ce = k > 4; e_wr = 1'b1; e_rd = !(k >= 2 && k <= 4); e_rsp = k == 5;
                e_dat = (k >= 2 && k <= 4) ? d : ZB;
            end
            act = {ce_n, write_n, read_n, req_ready, rsp_valid, address_bus, data_bus};
            exp = {e_ce, e_wr, e_rd, k == n, e_rsp, a, e_dat};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL txn wr=%0b cycle=%0d {ce,wr,rd,rdy,rsp,addr,data} got=%h want=%h", wr, k, act, exp);
            end
            if (!wr && k >= 5) begin
                n_checks++;
                if (rsp_rdata !== d) begin
                    n_fail++;
                    $display("FAIL txn_rdata cycle=%0d got=%h want=%h", k, rsp_rdata, d);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [24:0] act;
        repeat (2) @(negedge clk);
        act = {ce_n, write_n, read_n, req_ready, busy, rsp_valid, address_bus, data_bus, 1'b0};
        n_checks++;
        if (act !== {6'b111010, 7'h00, ZB, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_active got=%h want=%h", act, {6'b111010, 7'h00, ZB, 1'b0});
        end
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        act = {ce_n, write_n, read_n, req_ready, busy, rsp_valid, address_bus, data_bus, 1'b0};
        n_checks++;
        if (act !== {6'b111100, 7'h00, ZB, 1'b0} || rsp_rdata !== 8'h00 || ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release got=%h rdata=%h ready2=%b want=%h rdata=00 ready2=1",
                     act, rsp_rdata, ready2, {6'b111100, 7'h00, ZB, 1'b0});
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 7'h15, 8'h2A);
    endtask

    task automatic test_read();
        run_txn(1'b0, 7'h15, 8'h2A);
    endtask

    task automatic test_busy();
        logic [15:0] act, exp;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h10; req_wdata = 8'h11;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            act = {req_ready, address_bus, data_bus};
            exp = {k == 8, 7'h10, k <= 7 ? 8'h11 : ZB};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL busy_ignore cycle=%0d {rdy,addr,data} got=%h want=%h", k, act, exp);
            end
            req_addr  = k < 8 ? 7'(8'h20 + k) : 7'h33;
            req_wdata = k < 8 ? 8'(8'h30 + k) : 8'h44;
        end
        @(negedge clk);
        req_valid = 1'b0;
        act = {ce_n, address_bus, data_bus};
        n_checks++;
        if (act !== {1'b0, 7'h33, 8'h44}) begin
            n_fail++;
            $display("FAIL busy_second_accept got=%h want=%h", act, {1'b0, 7'h33, 8'h44});
        end
        for (int t = 0; t < 20 && req_ready !== 1'b1; t++) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_return_idle got=%b want=1", req_ready);
        end
        run_txn(1'b0, 7'h10, 8'h11);
        run_txn(1'b0, 7'h33, 8'h44);
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 7'h01, 8'h55);
        run_txn(1'b0, 7'h01, 8'h55);
        n_checks++;
        if (last_gap < 2) begin
            n_fail++;
            $display("FAIL b2b_ce_gap got=%0d want>=2", last_gap);
        end
    endtask

    task automatic test_reset_mid();
        logic [26:0] act, exp;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h40; req_wdata = 8'h77;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        n_checks++;
        if (write_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre_strobe write_n got=%b want=0", write_n);
        end
        reset = 1'b1;
        exp = {5'b11100, 7'h00, ZB, 8'h00, 1'b0};
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            act = {ce_n, write_n, read_n, req_ready, rsp_valid, address_bus, data_bus, rsp_rdata, 1'b0};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL mid_reset cycle=%0d got=%h want=%h", j, act, exp);
            end
            if (j == 3) reset = 1'b0;
        end
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            n_checks++;
            if ({req_ready, rsp_valid, ce_n} !== 3'b101) begin
                n_fail++;
                $display("FAIL mid_after_reset cycle=%0d {rdy,rsp,ce} got=%b want=101", j, {req_ready, rsp_valid, ce_n});
            end
        end
    endtask

    task automatic test_param_sweep();
        logic [19:0] act, exp;
        valid2 = 1'b1; write2 = 1'b0; addr2 = 7'h0A; wdata2 = 8'h00;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            valid2 = 1'b0;
            act = {ce_n2, write_n2, read_n2, ready2, rsp_valid2, address_bus2, data_bus2};
            exp = {k > 3, 1'b1, k != 3, k == 7, k == 4, 7'h0A, k == 3 ? 8'hC3 : ZB};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL sweep_read cycle=%0d got=%h want=%h", k, act, exp);
            end
            if (k == 4) begin
                n_checks++;
                if (rdata2 !== 8'hC3) begin
                    n_fail++;
                    $display("FAIL sweep_rdata got=%h want=c3", rdata2);
                end
            end
        end
        valid2 = 1'b1; write2 = 1'b1; addr2 = 7'h0B; wdata2 = 8'h5A;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            valid2 = 1'b0;
            act = {ce_n2, write_n2, read_n2, ready2, rsp_valid2, address_bus2, data_bus2};
            exp = {k > 3, k != 3, 1'b1, k == 7, 1'b0, 7'h0B, k <= 6 ? 8'h5A : ZB};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL sweep_write cycle=%0d got=%h want=%h", k, act, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
